// File: rtl/csr_perf_reader.sv
// csr_perf_reader: owns the core's 64-bit performance counters and serves
// 32-bit CSR reads through a valid/ready request channel and a registered
// response channel. A low-half read captures the matching high half into a
// per-counter snapshot, so a later high-half read returns a value from the
// same instant and a split 64-bit read cannot tear.
module csr_perf_reader #(
    parameter int XLEN = 32,
    parameter int PERF_CNT_LEN = 64,
    parameter logic [PERF_CNT_LEN-1:0] PERF_CNT_INC = 1,
    parameter int CSR_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ev_instr,
    input  logic                  ev_flush,
    input  logic                  ev_wait,
    input  logic                  ev_decod,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CSR_ADDR_W-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_data,
    output logic                  rsp_err
);

    localparam int N_CNT = 5;

    // The high-half alias of each counter differs from its low half only in
    // address bit 7, so decoding is done on the address with that bit masked.
    localparam logic [CSR_ADDR_W-1:0] HI_BIT     = CSR_ADDR_W'(12'h080);
    localparam logic [CSR_ADDR_W-1:0] ADDR_CYCLE = CSR_ADDR_W'(12'hC00);
    localparam logic [CSR_ADDR_W-1:0] ADDR_INSTR = CSR_ADDR_W'(12'hC02);
    localparam logic [CSR_ADDR_W-1:0] ADDR_FLUSH = CSR_ADDR_W'(12'hC03);
    localparam logic [CSR_ADDR_W-1:0] ADDR_WAIT  = CSR_ADDR_W'(12'hC04);
    localparam logic [CSR_ADDR_W-1:0] ADDR_DECOD = CSR_ADDR_W'(12'hC05);

    logic [PERF_CNT_LEN-1:0] cnt  [N_CNT];
    logic [XLEN-1:0]         snap [N_CNT];
    logic [N_CNT-1:0]        snap_vld;
    logic [N_CNT-1:0]        inc_en;

    logic [CSR_ADDR_W-1:0]   addr_lo;
    logic                    sel_hit;
    logic                    sel_hi;
    logic [2:0]              sel_idx;
    logic [XLEN-1:0]         rd_data;
    logic                    accept;

    // Index 0 is CYCLE, which counts unconditionally.
    assign inc_en    = {ev_decod, ev_wait, ev_flush, ev_instr, 1'b1};
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign addr_lo   = req_addr & ~HI_BIT;

    // Address decode: which counter, which half, and whether the address is a counter at all.
    always_comb begin
        sel_hit = 1'b1;
        sel_hi  = req_addr[7];
        sel_idx = 3'd0;
        if (addr_lo == ADDR_CYCLE) begin
            sel_idx = 3'd0;
        end else if (addr_lo == ADDR_INSTR) begin
            sel_idx = 3'd1;
        end else if (addr_lo == ADDR_FLUSH) begin
            sel_idx = 3'd2;
        end else if (addr_lo == ADDR_WAIT) begin
            sel_idx = 3'd3;
        end else if (addr_lo == ADDR_DECOD) begin
            sel_idx = 3'd4;
        end else begin
            sel_hit = 1'b0;
        end
    end

    // Read mux: low half is live; high half prefers a pending snapshot over the live value.
    always_comb begin
        rd_data = '0;
        if (sel_hit) begin
            if (!sel_hi) begin
                rd_data = cnt[sel_idx][XLEN-1:0];
            end else if (snap_vld[sel_idx]) begin
                rd_data = snap[sel_idx];
            end else begin
                rd_data = cnt[sel_idx][2*XLEN-1:XLEN];
            end
        end
    end

    // Free-running counters; reads never stall them and they wrap modulo 2^PERF_CNT_LEN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                if (inc_en[i]) begin
                    cnt[i] <= cnt[i] + PERF_CNT_INC;
                end
            end
        end
    end

    // Snapshot capture on low reads and consumption on high reads of the same counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CNT; i++) begin
                snap[i] <= '0;
            end
            snap_vld <= '0;
        end else if (accept && sel_hit) begin
            if (!sel_hi) begin
                snap[sel_idx]     <= cnt[sel_idx][2*XLEN-1:XLEN];
                snap_vld[sel_idx] <= 1'b1;
            end else begin
                snap_vld[sel_idx] <= 1'b0;
            end
        end
    end

    // Single-entry response buffer; contents hold while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rd_data;
            rsp_err   <= !sel_hit;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_perf_reader.sv
// Bench for csr_perf_reader: two instances share all stimulus, one with the
// default unit increment and one with a large increment so that low-half
// carries and full 64-bit wraps are reached within a few events.
module tb_csr_perf_reader;

    localparam logic [63:0] INC1 = 64'h8000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ev_instr = 1'b0, ev_flush = 1'b0, ev_wait = 1'b0, ev_decod = 1'b0;
    logic        req_valid = 1'b0;
    logic [11:0] req_addr = 12'h000;
    logic        rsp_ready = 1'b1;

    logic        rr0, rv0, re0, rr1, rv1, re1;
    logic [31:0] rd0, rd1;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state, index [instance][counter]
    logic [63:0] m_cnt  [2][5];
    logic [31:0] m_snap [2][5];
    bit          m_flag [2][5];
    bit          m_rv;
    logic [31:0] m_rd [2];
    bit          m_re [2];

    logic [11:0] addr_tab [16];

    always #5 clk = ~clk;

    csr_perf_reader u0 (
        .clk(clk), .rst(rst),
        .ev_instr(ev_instr), .ev_flush(ev_flush), .ev_wait(ev_wait), .ev_decod(ev_decod),
        .req_valid(req_valid), .req_ready(rr0), .req_addr(req_addr),
        .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_data(rd0), .rsp_err(re0)
    );

    csr_perf_reader #(.PERF_CNT_INC(INC1)) u1 (
        .clk(clk), .rst(rst),
        .ev_instr(ev_instr), .ev_flush(ev_flush), .ev_wait(ev_wait), .ev_decod(ev_decod),
        .req_valid(req_valid), .req_ready(rr1), .req_addr(req_addr),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1), .rsp_err(re1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] inc_of(input int k);
        return (k == 0) ? 64'd1 : INC1;
    endfunction

    // Counter map: low addresses C00,C02..C05; high alias adds 0x80.
    function automatic void dec(input logic [11:0] a, output bit hit, output int idx, output bit hi);
        logic [11:0] lo;
        lo  = a & 12'hF7F;
        hi  = a[7];
        hit = 1'b1;
        case (lo)
            12'hC00: idx = 0;
            12'hC02: idx = 1;
            12'hC03: idx = 2;
            12'hC04: idx = 3;
            12'hC05: idx = 4;
            default: begin idx = 0; hit = 1'b0; end
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) begin
                m_cnt[k][i]  = 64'd0;
                m_snap[k][i] = 32'd0;
                m_flag[k][i] = 1'b0;
            end
            m_rd[k] = 32'd0;
            m_re[k] = 1'b0;
        end
        m_rv = 1'b0;
    endtask

    // Model of one clock edge: response bookkeeping from pre-edge counters, then counting.
    task automatic model_edge(input bit acc);
        bit hit, hi;
        int idx;
        bit evs [5];
        if (acc) begin
            dec(req_addr, hit, idx, hi);
            for (int k = 0; k < 2; k++) begin
                if (!hit) begin
                    m_rd[k] = 32'd0;
                    m_re[k] = 1'b1;
                end else if (!hi) begin
                    m_rd[k] = m_cnt[k][idx][31:0];
                    m_snap[k][idx] = m_cnt[k][idx][63:32];
                    m_flag[k][idx] = 1'b1;
                    m_re[k] = 1'b0;
                end else begin
                    m_rd[k] = m_flag[k][idx] ? m_snap[k][idx] : m_cnt[k][idx][63:32];
                    m_flag[k][idx] = 1'b0;
                    m_re[k] = 1'b0;
                end
            end
            m_rv = 1'b1;
        end else if (rsp_ready) begin
            m_rv = 1'b0;
        end
        evs[0] = 1'b1;
        evs[1] = ev_instr;
        evs[2] = ev_flush;
        evs[3] = ev_wait;
        evs[4] = ev_decod;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) begin
                if (evs[i]) m_cnt[k][i] = m_cnt[k][i] + inc_of(k);
            end
        end
    endtask

    // One cycle: drive inputs just after an edge, check ready, clock, check response.
    task automatic step(input bit v, input logic [11:0] a, input bit rdy, input logic [3:0] ev);
        bit exp_rr;
        req_valid = v;
        req_addr  = a;
        rsp_ready = rdy;
        {ev_decod, ev_wait, ev_flush, ev_instr} = ev;
        #1;
        exp_rr = !m_rv || rdy;
        chk("req_ready0", rr0, exp_rr);
        chk("req_ready1", rr1, exp_rr);
        @(posedge clk);
        model_edge(v && exp_rr);
        #1;
        chk("rsp_valid0", rv0, m_rv);
        chk("rsp_valid1", rv1, m_rv);
        if (m_rv) begin
            chk("rsp_data0", rd0, m_rd[0]);
            chk("rsp_err0",  re0, m_re[0]);
            chk("rsp_data1", rd1, m_rd[1]);
            chk("rsp_err1",  re1, m_re[1]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        {ev_decod, ev_wait, ev_flush, ev_instr} = 4'b0;
        rsp_ready = 1'b1;
        #1;
        model_clear();
        chk("rst_rsp_valid0", rv0, 1'b0);
        chk("rst_rsp_valid1", rv1, 1'b0);
        chk("rst_rsp_data0", rd0, 32'd0);
        chk("rst_rsp_err0", re0, 1'b0);
        chk("rst_req_ready0", rr0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        addr_tab = '{12'hC00, 12'hC02, 12'hC03, 12'hC04, 12'hC05, 12'hC80, 12'hC82, 12'hC83,
                     12'hC84, 12'hC85, 12'hC01, 12'hC81, 12'h300, 12'hC06, 12'hB00, 12'hC00};
        model_clear();
        #2;
        do_reset();

        // Ten idle cycles, then CYCLE low reads back the pre-increment value 10.
        for (int i = 0; i < 10; i++) step(1'b0, 12'h000, 1'b1, 4'b0000);
        step(1'b1, 12'hC00, 1'b1, 4'b0000);
        chk("cycle_after_10", rd0, 32'd10);
        chk("cycle_lat_valid", rv0, 1'b1);

        // Error address leaves the CYCLE snapshot intact for the following high read.
        step(1'b1, 12'h300, 1'b1, 4'b0000);
        chk("err_flag", re0, 1'b1);
        chk("err_data", rd0, 32'd0);
        step(1'b1, 12'hC80, 1'b1, 4'b0000);
        step(1'b0, 12'h000, 1'b1, 4'b0000);
        chk("valid_drops", rv0, 1'b0);

        // Low-half carry on INSTR in the read cycle: snapshot keeps the old high half.
        do_reset();
        step(1'b0, 12'h000, 1'b1, 4'b0001);
        step(1'b1, 12'hC02, 1'b1, 4'b0001);
        chk("wrap_lo_u1", rd1, 32'h8000_0000);
        chk("wrap_lo_u0", rd0, 32'd1);
        step(1'b1, 12'hC82, 1'b1, 4'b0000);
        chk("wrap_hi_snap_u1", rd1, 32'h8000_0000);
        chk("wrap_hi_snap_u0", rd0, 32'd0);
        step(1'b1, 12'hC82, 1'b1, 4'b0000);
        chk("wrap_hi_live_u1", rd1, 32'h0000_0001);

        // High read of FLUSH with no prior low read returns live high, flag stays clear.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 1'b1, 4'b0010);
        step(1'b1, 12'hC83, 1'b1, 4'b0000);
        chk("live_hi_u1", rd1, 32'h8000_0001);
        step(1'b1, 12'hC83, 1'b1, 4'b0000);
        chk("live_hi_again_u1", rd1, 32'h8000_0001);

        // Consumer stall on a WAIT read: request blocked and response held.
        step(1'b1, 12'hC04, 1'b0, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 12'hC00, 1'b0, 4'b0100);
            chk("stall_ready", rr0, 1'b0);
        end
        step(1'b1, 12'hC00, 1'b1, 4'b0000);
        chk("stall_release_lo", rd0, m_cnt[0][0][31:0] - 32'd1);

        // Asynchronous reset with a response pending.
        step(1'b1, 12'hC04, 1'b0, 4'b1000);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid0", rv0, 1'b0);
        chk("async_rst_valid1", rv1, 1'b0);
        do_reset();
        step(1'b1, 12'hC05, 1'b1, 4'b0000);
        chk("decod_after_rst", rd0, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1) == 1, addr_tab[$urandom_range(0, 15)],
                 $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
